// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane helper.
package lsu_pkg;

  // Access size encoding as presented on op_size.
  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Exception codes reported on resp_exc_code.
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  // True when the access size cannot be served at this byte offset.
  function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      SZ_HALF: misaligned = addr_lo[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for word-organised memory: byte enables and replicated
// store data for writes, lane extraction plus sign/zero extension for reads.
// Purely combinational so it can be reused by refill logic.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Lane selection and extension for the requested size.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_WORD: be = 4'b1111;
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
      end
      default: be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit: accepts one CPU memory operation, checks alignment and
// range, runs a req/ready word access to data memory and returns the
// extended load result or an address exception. All outputs are registered.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] DM_BASE = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        accept, complete;
  logic        op_fault;
  size_e       op_size_e;
  logic [31:0] op_offset;

  // Fields kept for the load extraction at the end of the access.
  logic        lat_store;
  size_e       lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_addr_lo;

  // Lane helper interface.
  size_e       al_size;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign op_size_e = size_e'(op_size);

  // Offset from the window base; an address below the base wraps to a large
  // value, so one unsigned compare covers both range limits.
  assign op_offset = op_addr - DM_BASE;
  assign op_fault  = misaligned(op_size_e, op_addr[1:0]) || (op_offset >= DM_SIZE);

  // In IDLE the helper sees the incoming op (for be/wdata registered on
  // accept); afterwards it sees the latched op (for load extraction).
  assign al_size    = (state_q == IDLE) ? op_size_e     : lat_size;
  assign al_addr_lo = (state_q == IDLE) ? op_addr[1:0]  : lat_addr_lo;

  lsu_lane_align u_lane_align (
    .size        (al_size),
    .addr_lo     (al_addr_lo),
    .is_unsigned (lat_unsigned),
    .wdata       (op_wdata),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_rep   (al_wdata),
    .rdata_ext   (al_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the accept/complete strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: if (op_valid) begin
        accept  = 1'b1;
        state_d = op_fault ? RESP : REQ;
      end
      REQ: if (mem_ready) begin
        complete = 1'b1;
        state_d  = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the operation fields needed after the accept edge.
  always_ff @(posedge clk) begin
    // NOTE: these are pure datapath holding registers, only read after they
    // are written on accept, so they carry no reset.
    if (accept) begin
      lat_store    <= op_store;
      lat_size     <= op_size_e;
      lat_unsigned <= op_unsigned;
      lat_addr_lo  <= op_addr[1:0];
    end
  end

  // Registered CPU-side and memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_ready      <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_exc      <= 1'b0;
      resp_exc_code <= EXC_NONE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
    end else begin
      op_ready      <= (state_d == IDLE);
      resp_valid    <= (state_d == RESP);
      resp_exc      <= accept && op_fault;
      resp_exc_code <= (accept && op_fault) ? (op_store ? EXC_ADES : EXC_ADEL) : EXC_NONE;
      resp_rdata    <= (complete && !lat_store) ? al_rdata : 32'h0;
      if (accept && !op_fault) begin
        mem_req   <= 1'b1;
        mem_we    <= op_store;
        mem_addr  <= {op_addr[31:2], 2'b00};
        mem_be    <= al_be;
        mem_wdata <= al_wdata;
      end else if (complete) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed testbench for lsu_mem_master. Inputs change and outputs are
// sampled on the falling edge; cycle 1 is the cycle after the accept edge.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_store = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic        op_unsigned = 1'b0;
  logic [31:0] op_addr = '0;
  logic [31:0] op_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk           (clk),
    .reset         (reset),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_store      (op_store),
    .op_size       (op_size),
    .op_unsigned   (op_unsigned),
    .op_addr       (op_addr),
    .op_wdata      (op_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_exc      (resp_exc),
    .resp_exc_code (resp_exc_code),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  // What one operation looked like from the outside.
  typedef struct {
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [3:0]  be1;
    logic [31:0] wdata1;
    logic        req_ever;
    logic        unstable;
    int          lat;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic        ready_in_resp;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  // Issue one op, answer with mem_ready in cycle ready_at, record what happened.
  task automatic do_op(input logic store, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int ready_at, output obs_t o);
    o.req1 = 0; o.we1 = 0; o.addr1 = 0; o.be1 = 0; o.wdata1 = 0;
    o.req_ever = 0; o.unstable = 0; o.lat = 0; o.rdata = 0; o.exc = 0; o.code = 0;
    o.ready_in_resp = 0; o.valid_after = 0; o.ready_after = 0;
    for (int i = 0; i < 20 && op_ready !== 1'b1; i++) @(negedge clk);
    op_valid = 1'b1; op_store = store; op_size = size; op_unsigned = uns;
    op_addr = addr; op_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: only the accept edge may matter.
    op_valid = 1'b0; op_store = ~store; op_size = 2'b11; op_unsigned = ~uns;
    op_addr = 32'hFFFF_FFFF; op_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin
        o.req1 = mem_req; o.we1 = mem_we; o.addr1 = mem_addr;
        o.be1 = mem_be; o.wdata1 = mem_wdata;
      end
      if (mem_req === 1'b1) begin
        o.req_ever = 1'b1;
        if (mem_addr !== o.addr1 || mem_be !== o.be1 || mem_wdata !== o.wdata1 || mem_we !== o.we1)
          o.unstable = 1'b1;
      end
      if (resp_valid === 1'b1) begin
        o.lat = c; o.rdata = resp_rdata; o.exc = resp_exc; o.code = resp_exc_code;
        o.ready_in_resp = op_ready;
        break;
      end
      mem_ready = (c == ready_at);
      mem_rdata = (c == ready_at) ? rdata : 32'hA5A5_A5A5;
      @(posedge clk);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    o.valid_after = resp_valid;
    o.ready_after = op_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({op_ready, resp_valid, resp_exc, mem_req, mem_we} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 10000", {op_ready, resp_valid, resp_exc, mem_req, mem_we});
    end
    tests_run++;
    if ({resp_rdata, resp_exc_code, mem_addr, mem_be, mem_wdata} !== '0) begin
      fails++; $display("FAIL reset_data: rdata=%h code=%0d addr=%h be=%b wdata=%h want all 0",
                        resp_rdata, resp_exc_code, mem_addr, mem_be, mem_wdata);
    end
  endtask

  task automatic test_store_word();
    obs_t o;
    do_op(1'b1, 2'b00, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 3, o);
    tests_run++;
    if ({o.req1, o.we1, o.be1} !== 6'b11_1111) begin
      fails++; $display("FAIL sw_req: req=%b we=%b be=%b want 1 1 1111", o.req1, o.we1, o.be1);
    end
    tests_run++;
    if (o.addr1 !== 32'h10 || o.wdata1 !== 32'h1234_5678) begin
      fails++; $display("FAIL sw_addr_data: addr=%h wdata=%h want 00000010 12345678", o.addr1, o.wdata1);
    end
    tests_run++;
    if (o.unstable !== 1'b0) begin
      fails++; $display("FAIL sw_stable: request fields changed while mem_req held, want stable");
    end
    tests_run++;
    if (o.lat !== 4) begin
      fails++; $display("FAIL sw_latency: resp in cycle %0d want 4", o.lat);
    end
    tests_run++;
    if ({o.exc, o.code, o.rdata} !== '0) begin
      fails++; $display("FAIL sw_resp: exc=%b code=%0d rdata=%h want 0 0 0", o.exc, o.code, o.rdata);
    end
    tests_run++;
    if ({o.ready_in_resp, o.valid_after, o.ready_after} !== 3'b001) begin
      fails++; $display("FAIL sw_pulse: ready_in_resp=%b valid_after=%b ready_after=%b want 0 0 1",
                        o.ready_in_resp, o.valid_after, o.ready_after);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    do_op(1'b1, 2'b10, 1'b0, 32'h23, 32'hCDEF_12AB, 32'h0, 1, o);
    tests_run++;
    if (o.addr1 !== 32'h20 || o.be1 !== 4'b1000 || o.wdata1 !== 32'hABAB_ABAB) begin
      fails++; $display("FAIL sb: addr=%h be=%b wdata=%h want 00000020 1000 abababab", o.addr1, o.be1, o.wdata1);
    end
    tests_run++;
    if (o.lat !== 2) begin
      fails++; $display("FAIL sb_latency: resp in cycle %0d want 2", o.lat);
    end
    do_op(1'b1, 2'b01, 1'b0, 32'h2E, 32'h0000_BEEF, 32'h0, 1, o);
    tests_run++;
    if (o.addr1 !== 32'h2C || o.be1 !== 4'b1100 || o.wdata1 !== 32'hBEEF_BEEF) begin
      fails++; $display("FAIL sh: addr=%h be=%b wdata=%h want 0000002c 1100 beefbeef", o.addr1, o.be1, o.wdata1);
    end
    // Last byte inside the window.
    do_op(1'b1, 2'b10, 1'b0, 32'h2FFF, 32'h5C, 32'h0, 1, o);
    tests_run++;
    if ({o.req1, o.exc} !== 2'b10 || o.addr1 !== 32'h2FFC || o.be1 !== 4'b1000) begin
      fails++; $display("FAIL sb_top: req=%b exc=%b addr=%h be=%b want 1 0 00002ffc 1000", o.req1, o.exc, o.addr1, o.be1);
    end
  endtask

  task automatic test_loads();
    obs_t o;
    do_op(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0000_8000, 2, o);
    tests_run++;
    if ({o.req1, o.we1, o.be1} !== 6'b10_0010 || o.addr1 !== 32'h20) begin
      fails++; $display("FAIL lb_req: req=%b we=%b be=%b addr=%h want 1 0 0010 00000020", o.req1, o.we1, o.be1, o.addr1);
    end
    tests_run++;
    if (o.lat !== 3 || o.rdata !== 32'hFFFF_FF80) begin
      fails++; $display("FAIL lb: lat=%0d rdata=%h want 3 ffffff80", o.lat, o.rdata);
    end
    do_op(1'b0, 2'b10, 1'b1, 32'h21, 32'h0, 32'h0000_8000, 2, o);
    tests_run++;
    if (o.rdata !== 32'h0000_0080) begin
      fails++; $display("FAIL lbu: rdata=%h want 00000080", o.rdata);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h03, 32'h0, 32'h7F00_0000, 1, o);
    tests_run++;
    if (o.rdata !== 32'h0000_007F) begin
      fails++; $display("FAIL lb_pos: rdata=%h want 0000007f", o.rdata);
    end
    do_op(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 32'h8001_0000, 1, o);
    tests_run++;
    if (o.be1 !== 4'b1100 || o.rdata !== 32'hFFFF_8001 || o.lat !== 2) begin
      fails++; $display("FAIL lh: be=%b rdata=%h lat=%0d want 1100 ffff8001 2", o.be1, o.rdata, o.lat);
    end
    do_op(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 32'h8001_0000, 1, o);
    tests_run++;
    if (o.rdata !== 32'h0000_8001) begin
      fails++; $display("FAIL lhu: rdata=%h want 00008001", o.rdata);
    end
    do_op(1'b0, 2'b00, 1'b0, 32'h04, 32'h0, 32'h89AB_CDEF, 1, o);
    tests_run++;
    if (o.rdata !== 32'h89AB_CDEF || o.be1 !== 4'b1111 || o.exc !== 1'b0) begin
      fails++; $display("FAIL lw: rdata=%h be=%b exc=%b want 89abcdef 1111 0", o.rdata, o.be1, o.exc);
    end
  endtask

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [4:0]  code;
  } fvec_t;

  task automatic test_faults();
    obs_t  o;
    fvec_t fv [5];
    fv[0] = '{store: 1'b0, size: 2'b00, addr: 32'h0000_0006, code: 5'd4};
    fv[1] = '{store: 1'b1, size: 2'b01, addr: 32'h0000_3000, code: 5'd5};
    fv[2] = '{store: 1'b0, size: 2'b01, addr: 32'h0000_0001, code: 5'd4};
    fv[3] = '{store: 1'b0, size: 2'b11, addr: 32'h0000_0000, code: 5'd4};
    fv[4] = '{store: 1'b1, size: 2'b00, addr: 32'hFFFF_FFFC, code: 5'd5};
    for (int i = 0; i < 5; i++) begin
      do_op(fv[i].store, fv[i].size, 1'b0, fv[i].addr, 32'h1111_1111, 32'h2222_2222, 1, o);
      tests_run++;
      if (o.req_ever !== 1'b0 || o.lat !== 1) begin
        fails++; $display("FAIL fault%0d_flow: req_seen=%b lat=%0d want 0 1", i, o.req_ever, o.lat);
      end
      tests_run++;
      if (o.exc !== 1'b1 || o.code !== fv[i].code || o.rdata !== 32'h0) begin
        fails++; $display("FAIL fault%0d_resp: exc=%b code=%0d rdata=%h want 1 %0d 0", i, o.exc, o.code, o.rdata, fv[i].code);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  req_vec, valid_vec, ready_vec;
    logic [31:0] rd2;
    rd2 = '0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0; op_addr = 32'h100;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      req_vec[c-1]   = mem_req;
      valid_vec[c-1] = resp_valid;
      ready_vec[c-1] = op_ready;
      if (c == 2) rd2 = resp_rdata;
    end
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_vec !== 7'b1001001) begin
      fails++; $display("FAIL b2b_req: got %b want 1001001", req_vec);
    end
    tests_run++;
    if (valid_vec !== 7'b0010010) begin
      fails++; $display("FAIL b2b_valid: got %b want 0010010", valid_vec);
    end
    tests_run++;
    if (ready_vec !== 7'b0100100) begin
      fails++; $display("FAIL b2b_ready: got %b want 0100100", ready_vec);
    end
    tests_run++;
    if (rd2 !== 32'h0000_0077) begin
      fails++; $display("FAIL b2b_rdata: got %h want 00000077", rd2);
    end
  endtask

  task automatic test_reset_mid_req();
    int stray;
    stray = 0;
    @(negedge clk);
    mem_ready = 1'b0;
    op_valid = 1'b1; op_store = 1'b0; op_size = 2'b00; op_unsigned = 1'b0; op_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1) begin
      fails++; $display("FAIL rst_req_setup: mem_req=%b want 1", mem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({mem_req, resp_valid, op_ready} !== 3'b001) begin
      fails++; $display("FAIL rst_mid_req: req=%b valid=%b ready=%b want 0 0 1", mem_req, resp_valid, op_ready);
    end
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_req !== 1'b0) stray++;
    end
    mem_ready = 1'b0;
    tests_run++;
    if (stray !== 0) begin
      fails++; $display("FAIL rst_abandon: %0d cycles with resp_valid/mem_req after reset, want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_faults();
    test_back_to_back();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Hard stop in case a wait ever runs away.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
